planificador_mantenimiento: RTL

Scheduler that shares the single maintenance FSM between NUM_SOL requesters (machines). It arbitrates pending requests round-robin and issues a one-cycle `iniciar` pulse to the maintenance FSM. It then waits for `terminado`, or aborts the job with a one-cycle `detener` pulse after TIMEOUT cycles. It sits directly above the maintenance FSM and drives its `iniciar` and `detener` inputs.

---
 rtl/planificador_mantenimiento.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/planificador_mantenimiento.sv
// Round-robin scheduler that shares one maintenance FSM between NUM_SOL requesters.
// Define PRIORIDAD_FIJA_EN for fixed lowest-index-wins arbitration instead of round-robin.
module planificador_mantenimiento #(
  parameter int unsigned NUM_SOL       = 4,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned ESPERA_CICLOS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SOL-1:0]         sol,
  input  logic                       terminado,
  output logic                       iniciar,
  output logic                       detener,
  output logic [$clog2(NUM_SOL)-1:0] activo_id,
  output logic                       ocupado,
  output logic [NUM_SOL-1:0]         conc,
  output logic                       abortado,
  output logic [7:0]                 cuenta_servicios
);

  localparam int unsigned IW = $clog2(NUM_SOL);
  localparam int unsigned TW = $clog2(TIMEOUT + ESPERA_CICLOS);

  typedef enum logic [2:0] {LIBRE, ARRANQUE, EN_CURSO, DETENER, ESPERA} estado_t;

  estado_t           estado_q;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     activo_id_q;
  logic              iniciar_q;
  logic              detener_q;
  logic              abortado_q;
  logic              ocupado_q;
  logic [NUM_SOL-1:0] conc_q;
  logic [7:0]        cuenta_q;

  logic              hit_d;
  logic [IW-1:0]     grant_d;
  int unsigned       idx;
  logic [NUM_SOL-1:0] desplazado;

`ifndef PRIORIDAD_FIJA_EN
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     siguiente;

  assign siguiente = (activo_id_q == IW'(NUM_SOL - 1)) ? '0 : activo_id_q + 1'b1;
`endif

  // Scan starts at ptr (or 0 for fixed priority); first set bit wins.
  always_comb begin
    hit_d      = 1'b0;
    grant_d    = '0;
    idx        = 0;
    desplazado = '0;
    for (int unsigned k = 0; k < NUM_SOL; k++) begin
`ifdef PRIORIDAD_FIJA_EN
      idx = k;
`else
      idx = (32'(ptr_q) + k) % NUM_SOL;
`endif
      desplazado = sol >> idx;
      if (!hit_d && desplazado[0]) begin
        hit_d   = 1'b1;
        grant_d = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= LIBRE;
      timer_q     <= '0;
      activo_id_q <= '0;
      iniciar_q   <= 1'b0;
      detener_q   <= 1'b0;
      abortado_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      conc_q      <= '0;
      cuenta_q    <= '0;
`ifndef PRIORIDAD_FIJA_EN
      ptr_q       <= '0;
`endif
    end else begin
      iniciar_q  <= 1'b0;
      detener_q  <= 1'b0;
      abortado_q <= 1'b0;
      conc_q     <= '0;
      case (estado_q)
        LIBRE: begin
          if (hit_d) begin
            activo_id_q <= grant_d;
            iniciar_q   <= 1'b1;
            ocupado_q   <= 1'b1;
            estado_q    <= ARRANQUE;
          end
        end
        ARRANQUE: begin
          timer_q  <= '0;
          estado_q <= EN_CURSO;
        end
        EN_CURSO: begin
          // Completion has priority over a coinciding timeout.
          if (terminado) begin
            conc_q   <= NUM_SOL'(1) << activo_id_q;
            if (cuenta_q != 8'hFF) cuenta_q <= cuenta_q + 8'd1;
`ifndef PRIORIDAD_FIJA_EN
            ptr_q    <= siguiente;
`endif
            timer_q  <= '0;
            estado_q <= ESPERA;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            detener_q  <= 1'b1;
            abortado_q <= 1'b1;
            estado_q   <= DETENER;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DETENER: begin
`ifndef PRIORIDAD_FIJA_EN
          ptr_q    <= siguiente;
`endif
          timer_q  <= '0;
          estado_q <= ESPERA;
        end
        ESPERA: begin
          if (timer_q == TW'(ESPERA_CICLOS - 1)) begin
            ocupado_q <= 1'b0;
            estado_q  <= LIBRE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          ocupado_q <= 1'b0;
          estado_q  <= LIBRE;
        end
      endcase
    end
  end

  assign iniciar          = iniciar_q;
  assign detener          = detener_q;
  assign activo_id        = activo_id_q;
  assign ocupado          = ocupado_q;
  assign conc             = conc_q;
  assign abortado         = abortado_q;
  assign cuenta_servicios = cuenta_q;

endmodule
